// File: rtl/rle_transmitter.sv
// rle_transmitter: run-length encodes row-structured elements into packed 32-bit words
// for the IO decoder: two header words, then MSB-first packets, one word per Bus_Ack.
module rle_transmitter #(
  parameter int DATA_WIDTH = 64,
  parameter int MAX_PACKET = 16
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  Start,
  input  logic [5:0]            Packet_Size,
  input  logic [15:0]           Rows_Num,
  input  logic                  Elem_Valid,
  output logic                  Elem_Ready,
  input  logic [DATA_WIDTH-1:0] Elem_Data,
  input  logic                  Elem_Last,
  output logic [31:0]           CPU_Bus,
  output logic                  Bus_Valid,
  input  logic                  Bus_Ack,
  output logic                  Busy,
  output logic                  Done
);
  localparam int CW = MAX_PACKET - 1;
  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam logic [3:0] IDLE      = 4'd0;
  localparam logic [3:0] HDR0      = 4'd1;
  localparam logic [3:0] HDR1      = 4'd2;
  localparam logic [3:0] LOAD      = 4'd3;
  localparam logic [3:0] ENCODE    = 4'd4;
  localparam logic [3:0] SPLIT     = 4'd5;
  localparam logic [3:0] TERM      = 4'd6;
  localparam logic [3:0] FLUSH     = 4'd7;
  localparam logic [3:0] WAIT_LAST = 4'd8;
  localparam logic [3:0] DONE      = 4'd9;

  logic [3:0]            state;
  logic [5:0]            p_r;
  logic [15:0]           rows_r;
  logic [15:0]           row_cnt;
  logic                  tag;
  logic                  run_val;
  logic [CW-1:0]         run_cnt;
  logic [DATA_WIDTH-1:0] sh;
  logic [BW-1:0]         bits_left;
  logic                  last_r;
  logic [31:0]           asm_word;
  logic [5:0]            asm_pos;

  logic [CW-1:0]         lim;
  logic                  asm_full;
  logic                  out_free;
  logic                  go;
  logic                  move;
  logic                  bit_in;
  logic                  row_end;
  logic                  overflow;
  logic                  emit;
  logic [MAX_PACKET-1:0] pkt;
  logic [5:0]            base_pos;
  logic [5:0]            shift;
  logic [31:0]           asm_next;
  logic [5:0]            pos_next;
  logic                  valid_next;
  logic [31:0]           bus_next;

  always_comb begin
    lim        = CW'((MAX_PACKET'(1) << (p_r - 6'd1)) - MAX_PACKET'(1));
    asm_full   = 7'(asm_pos) + 7'(p_r) > 7'd32;
    out_free   = !Bus_Valid || Bus_Ack;
    go         = !asm_full || out_free;
    move       = ((state == LOAD || state == ENCODE || state == SPLIT || state == TERM) && asm_full && out_free)
                 || (state == FLUSH && out_free);
    bit_in     = sh[DATA_WIDTH-1];
    row_end    = state == ENCODE && bits_left == '0;
    overflow   = state == ENCODE && !row_end && bit_in == run_val && run_cnt == lim;
    emit       = go && ((state == ENCODE && (row_end || bit_in != run_val || overflow))
                        || state == SPLIT || state == TERM);
    // only ENCODE packets carry a length; at overflow run_cnt already equals the limit
    pkt        = (MAX_PACKET'(tag) << (p_r - 6'd1)) | MAX_PACKET'(state == ENCODE ? run_cnt : '0);
    base_pos   = move ? 6'd0 : asm_pos;
    shift      = 6'd32 - base_pos - p_r;
    asm_next   = (move ? 32'd0 : asm_word) | (emit ? 32'(pkt) << shift : 32'd0);
    pos_next   = emit ? base_pos + p_r : base_pos;
    valid_next = move || (state == IDLE && Start) ? 1'b1 : state == HDR0 ? Bus_Valid : Bus_Valid && !Bus_Ack;
    bus_next   = move ? asm_word
               : state == IDLE && Start ? {26'd0, Packet_Size}
               : state == HDR0 && Bus_Valid && Bus_Ack ? {16'd0, rows_r}
               : CPU_Bus;
    Elem_Ready = state == LOAD && go;
    Busy       = state != IDLE && state != DONE;
    Done       = state == DONE;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= IDLE;
      p_r       <= '0;
      rows_r    <= '0;
      row_cnt   <= '0;
      tag       <= 1'b0;
      run_val   <= 1'b0;
      run_cnt   <= '0;
      sh        <= '0;
      bits_left <= '0;
      last_r    <= 1'b0;
      asm_word  <= '0;
      asm_pos   <= '0;
      CPU_Bus   <= '0;
      Bus_Valid <= 1'b0;
    end else begin
      asm_word  <= asm_next;
      asm_pos   <= pos_next;
      CPU_Bus   <= bus_next;
      Bus_Valid <= valid_next;
      case (state)
        IDLE: if (Start) begin
          p_r     <= Packet_Size;
          rows_r  <= Rows_Num;
          row_cnt <= '0;
          tag     <= 1'b0;
          run_val <= 1'b0;
          run_cnt <= '0;
          state   <= HDR0;
        end
        HDR0: if (Bus_Valid && Bus_Ack) state <= HDR1;
        HDR1: if (Bus_Valid && Bus_Ack) state <= LOAD;
        LOAD: if (Elem_Valid && Elem_Ready) begin
          sh        <= Elem_Data;
          last_r    <= Elem_Last;
          bits_left <= BW'(DATA_WIDTH);
          state     <= ENCODE;
        end
        ENCODE: if (go) begin
          if (row_end) begin
            tag     <= !tag;
            run_val <= !tag;
            run_cnt <= '0;
            row_cnt <= row_cnt + 16'd1;
            state   <= row_cnt + 16'd1 == rows_r ? TERM : LOAD;
          end else begin
            sh        <= sh << 1;
            bits_left <= bits_left - BW'(1);
            run_val   <= bit_in;
            run_cnt   <= bit_in != run_val || overflow ? CW'(1) : run_cnt + CW'(1);
            // a last-element row stays in ENCODE for one extra cycle to emit the closing run
            state     <= overflow ? SPLIT : bits_left == BW'(1) && !last_r ? LOAD : ENCODE;
          end
        end
        SPLIT: if (go) state <= bits_left == '0 && !last_r ? LOAD : ENCODE;
        TERM: if (go) state <= FLUSH;
        FLUSH: if (out_free) state <= WAIT_LAST;
        WAIT_LAST: if (Bus_Valid && Bus_Ack) state <= DONE;
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rle_transmitter.sv
// tb_rle_transmitter: scoreboard bench; expected words come from a run-list model of the
// packet format, a bus-side monitor acks randomly and pops/compares each handshaked word.
module tb_rle_transmitter;
  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        Start = 1'b0;
  logic [5:0]  Packet_Size = '0;
  logic [15:0] Rows_Num = '0;
  logic        Elem_Valid = 1'b0;
  logic        Elem_Ready;
  logic [63:0] Elem_Data = '0;
  logic        Elem_Last = 1'b0;
  logic [31:0] CPU_Bus;
  logic        Bus_Valid;
  logic        Bus_Ack = 1'b0;
  logic        Busy;
  logic        Done;

  int          n_vec = 0;
  int          n_err = 0;
  int          n_hs = 0;
  bit          hold_ack = 1'b0;
  logic [31:0] exp_q[$];
  logic [63:0] els[$];
  bit          lasts[$];

  rle_transmitter #(.DATA_WIDTH(64), .MAX_PACKET(16)) dut (
    .CLK(CLK), .RST_N(RST_N), .Start(Start), .Packet_Size(Packet_Size), .Rows_Num(Rows_Num),
    .Elem_Valid(Elem_Valid), .Elem_Ready(Elem_Ready), .Elem_Data(Elem_Data), .Elem_Last(Elem_Last),
    .CPU_Bus(CPU_Bus), .Bus_Valid(Bus_Valid), .Bus_Ack(Bus_Ack), .Busy(Busy), .Done(Done)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic give_up(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s: got no response, expected one within the cycle budget", nm);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  endtask

  // bus-side monitor: random acks, one scoreboard pop per handshake
  initial forever begin
    @(negedge CLK);
    if (!RST_N) Bus_Ack = 1'b0;
    else begin
      Bus_Ack = !hold_ack && ($urandom_range(2) != 0);
      if (Bus_Valid && Bus_Ack) begin
        n_hs++;
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL extra_word: got %0h expected no word", CPU_Bus);
        end else check("bus_word", CPU_Bus, exp_q.pop_front());
      end
    end
  end

  // reference: split each row into alternating runs, chunk long runs, pack slots into words
  task automatic build_expected(input int p, input int nrows);
    int m, tag, e, slot, k, cur, len, l;
    bit b[$];
    int runs[$];
    int pk[$];
    logic [31:0] w;
    m = (1 << (p - 1)) - 1;
    k = 32 / p;
    tag = 0; e = 0; slot = 0; w = '0;
    exp_q.push_back(32'(p));
    exp_q.push_back(32'(nrows));
    for (int r = 0; r < nrows; r++) begin
      b.delete(); runs.delete();
      cur = tag; len = 0;
      do begin
        for (int i = 63; i >= 0; i--) b.push_back(els[e][i]);
        e++;
      end while (!lasts[e-1]);
      foreach (b[i]) begin
        if (int'(b[i]) == cur) len++;
        else begin runs.push_back(len); cur = 1 - cur; len = 1; end
      end
      runs.push_back(len);
      foreach (runs[j]) begin
        l = runs[j];
        while (l > m) begin
          pk.push_back((tag << (p - 1)) | m);
          pk.push_back(tag << (p - 1));
          l -= m;
        end
        pk.push_back((tag << (p - 1)) | l);
      end
      tag ^= 1;
    end
    pk.push_back(tag << (p - 1));
    foreach (pk[j]) begin
      w |= 32'(pk[j]) << (32 - (slot + 1) * p);
      slot++;
      if (slot == k) begin exp_q.push_back(w); w = '0; slot = 0; end
    end
    if (slot > 0) exp_q.push_back(w);
  endtask

  function automatic logic [63:0] rand_elem();
    case ($urandom_range(3))
      0: return 64'h0;
      1: return {64{1'b1}};
      2: return {$urandom, $urandom};
      default: return {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
    endcase
  endfunction

  task automatic start_frame(input int p, input int nrows);
    @(negedge CLK);
    Packet_Size = 6'(p);
    Rows_Num = 16'(nrows);
    Start = 1'b1;
    @(negedge CLK);
    Start = 1'b0;
    check("hdr0_valid", Bus_Valid, 1);
    check("busy_after_start", Busy, 1);
  endtask

  task automatic feed(input int first, input int last_idx, input bit glitch);
    for (int i = first; i <= last_idx; i++) begin
      Elem_Valid = 1'b0;
      if (glitch && i == first) begin
        Start = 1'b1; Packet_Size = 6'd5; Rows_Num = 16'd9;
        @(negedge CLK);
        Start = 1'b0;
      end
      repeat ($urandom_range(2)) @(negedge CLK);
      Elem_Valid = 1'b1;
      Elem_Data = els[i];
      Elem_Last = lasts[i];
      for (int t = 0; !Elem_Ready; t++) begin
        if (t > 5000) give_up("elem_accept");
        @(negedge CLK);
      end
      @(negedge CLK);
    end
    Elem_Valid = 1'b0;
  endtask

  task automatic wait_done();
    bit rdy;
    rdy = 1'b0;
    for (int t = 0; !Done; t++) begin
      if (t > 20000) give_up("done");
      rdy |= Elem_Ready;
      @(negedge CLK);
    end
    check("ready_after_last_row", rdy, 0);
    check("busy_at_done", Busy, 0);
    check("words_left_at_done", exp_q.size(), 0);
  endtask

  task automatic directed(input int p, input int nrows, input logic [31:0] w0, input logic [31:0] w1);
    exp_q.push_back(32'(p)); exp_q.push_back(32'(nrows));
    exp_q.push_back(w0); exp_q.push_back(w1);
    start_frame(p, nrows);
    feed(0, els.size() - 1, 1'b0);
    wait_done();
  endtask

  task automatic rand_frame(input bit glitch);
    int p, nr, ne;
    p = $urandom_range(16, 3);
    nr = $urandom_range(3, 1);
    els.delete(); lasts.delete();
    for (int r = 0; r < nr; r++) begin
      ne = $urandom_range(3, 1);
      for (int j = 0; j < ne; j++) begin
        els.push_back(rand_elem());
        lasts.push_back(j == ne - 1);
      end
    end
    build_expected(p, nr);
    start_frame(p, nr);
    feed(0, els.size() - 1, glitch);
    wait_done();
  endtask

  task automatic check_reset_outputs(input string nm);
    check({nm, "_bus"}, CPU_Bus, 0);
    check({nm, "_valid"}, Bus_Valid, 0);
    check({nm, "_ready"}, Elem_Ready, 0);
    check({nm, "_busy"}, Busy, 0);
    check({nm, "_done"}, Done, 0);
  endtask

  logic [31:0] held;
  int          chg;
  bit          rdy_seen;

  initial begin
    repeat (3) @(negedge CLK);
    check_reset_outputs("reset");
    RST_N = 1'b1;
    // all-zero element, P=6: overflow splits and a terminator spilling into a second word
    els.delete(); lasts.delete();
    els.push_back(64'h0); lasts.push_back(1'b1);
    directed(6, 1, 32'h7C07_C008, 32'h8000_0000);
    // leading zero-length run, then both run values overflowing
    els.delete(); lasts.delete();
    els.push_back(64'hFFFF_FFFF_0000_0000); lasts.push_back(1'b1);
    directed(6, 1, 32'h01F0_017C, 32'h0018_0000);
    // two rows with tag toggle, P=8 fills words exactly
    els.delete(); lasts.delete();
    els.push_back(64'h8000_0000_0000_0000); lasts.push_back(1'b1);
    els.push_back(64'h8000_0000_0000_0000); lasts.push_back(1'b1);
    directed(8, 2, 32'h0001_3F81, 32'hBF00_0000);
    // Start pulsed while busy must not disturb the stream
    rand_frame(1'b1);
    // backpressure: hold Bus_Ack with the assembly word full
    els.delete(); lasts.delete();
    els.push_back(64'h0); lasts.push_back(1'b0);
    els.push_back(64'h0); lasts.push_back(1'b1);
    build_expected(3, 1);
    n_hs = 0;
    start_frame(3, 1);
    fork
      feed(0, 1, 1'b0);
      begin
        for (int t = 0; n_hs < 3; t++) begin
          if (t > 2000) give_up("first_data_word");
          @(negedge CLK);
        end
        hold_ack = 1'b1;
        repeat (70) @(negedge CLK);
        held = CPU_Bus;
        chg = 0;
        rdy_seen = 1'b0;
        repeat (20) begin
          @(negedge CLK);
          chg += int'(CPU_Bus != held);
          rdy_seen |= Elem_Ready;
        end
        check("hold_bus_changes", chg, 0);
        check("hold_elem_ready", rdy_seen, 0);
        check("hold_bus_valid", Bus_Valid, 1);
        check("hold_busy", Busy, 1);
        hold_ack = 1'b0;
      end
    join
    wait_done();
    // reset in the middle of ENCODE, then a clean frame
    els.delete(); lasts.delete();
    els.push_back({$urandom, $urandom}); lasts.push_back(1'b0);
    els.push_back({$urandom, $urandom}); lasts.push_back(1'b1);
    build_expected(6, 1);
    start_frame(6, 1);
    feed(0, 0, 1'b0);
    repeat (10) @(negedge CLK);
    RST_N = 1'b0;
    @(negedge CLK);
    check_reset_outputs("abort");
    exp_q.delete();
    Elem_Valid = 1'b0;
    RST_N = 1'b1;
    rand_frame(1'b0);
    for (int i = 0; i < 15; i++) rand_frame(1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
